// File: rtl/wb_port_arbiter_pkg.sv
// Shared CPU writeback definitions: register-file geometry, the writeback entry
// record and a helper for sizing occupancy counters.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus: ALU and load producers in, register-file write port and
// pending bitmap out.
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_W-1:0]     alu_addr;
    logic [DATA_W-1:0]     alu_data;
    logic                  mem_valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data;
    logic                  enc;
    logic [ADDR_W-1:0]     addrc;
    logic [DATA_W-1:0]     datac;
    logic [2**ADDR_W-1:0]  pending;
    logic [CNT_W-1:0]      fifo_count;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, enc, addrc, datac, pending, fifo_count
    );

    // Producer / register-file side.
    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, enc, addrc, datac, pending, fifo_count
    );

endinterface

// File: rtl/wb_port_arbiter_wb_fifo.sv
// In-order overflow FIFO for ALU results that lose arbitration. Exposes a
// per-slot valid+addr view so the parent can build the pending bitmap.
module wb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic [DEPTH-1:0]  o_valid,
    output logic [ADDR_W-1:0] o_entry_addr [DEPTH]
);
    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Payload storage; contents are only meaningful where r_valid is set.
    always_ff @(posedge clock) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_addr;
            r_data[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (i_pop) begin
                r_rd_ptr          <= r_rd_ptr + 1'b1;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (i_push) begin
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_addr  = r_addr[r_rd_ptr];
    assign o_head_data  = r_data[r_rd_ptr];
    assign o_count      = r_count;
    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == FULL_CNT);
    assign o_valid      = r_valid;
    assign o_entry_addr = r_addr;

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: merges load and ALU results onto the single register-file
// write port. Loads win; displaced ALU results queue in order in wb_fifo.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic             clock,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = cnt_width(DEPTH);
    localparam int unsigned NUM_RF = 2**ADDR_W;

    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [DEPTH-1:0]  w_valid;
    logic [ADDR_W-1:0] w_entry_addr [DEPTH];

    logic              w_alu_ready;
    logic              w_alu_live;
    logic              w_mem_live;
    logic              w_push;
    logic              w_pop;
    logic              w_sel_valid;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [NUM_RF-1:0] w_pending;

    logic              r_enc;
    logic [ADDR_W-1:0] r_addrc;
    logic [DATA_W-1:0] r_datac;

    // Ready depends only on occupancy, so a same-cycle pop never enables a push.
    assign w_alu_ready = !w_full;
    // Writes to register 0 are consumed but otherwise behave as if absent.
    assign w_alu_live  = bus.alu_valid && w_alu_ready && (bus.alu_addr != '0);
    assign w_mem_live  = bus.mem_valid && (bus.mem_addr != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_addr      (bus.alu_addr),
        .i_data      (bus.alu_data),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_valid     (w_valid),
        .o_entry_addr(w_entry_addr)
    );

    // Source selection: load, then FIFO head, then ALU bypass (FIFO empty only).
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = bus.mem_addr;
        w_sel_data  = bus.mem_data;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (w_mem_live) begin
            w_sel_valid = 1'b1;
            w_push      = w_alu_live;
        end else if (!w_empty) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = w_head_addr;
            w_sel_data  = w_head_data;
            w_pop       = 1'b1;
            w_push      = w_alu_live;
        end else if (w_alu_live) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = bus.alu_addr;
            w_sel_data  = bus.alu_data;
        end
    end

    // Output register; address/data hold when no write is selected.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enc   <= 1'b0;
            r_addrc <= '0;
            r_datac <= '0;
        end else begin
            r_enc <= w_sel_valid;
            if (w_sel_valid) begin
                r_addrc <= w_sel_addr;
                r_datac <= w_sel_data;
            end
        end
    end

    // Pending bitmap from registered state only: queued entries plus the output slot.
    always_comb begin
        w_pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) begin
                w_pending[w_entry_addr[i]] = 1'b1;
            end
        end
        if (r_enc) begin
            w_pending[r_addrc] = 1'b1;
        end
    end

    assign bus.alu_ready  = w_alu_ready;
    assign bus.enc        = r_enc;
    assign bus.addrc      = r_addrc;
    assign bus.datac      = r_datac;
    assign bus.pending    = w_pending;
    assign bus.fifo_count = w_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, multi-cycle
// corner sequences and a randomised scoreboard run.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_port_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_port_arbiter #(
        .DEPTH (DEPTH),
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_enc;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs [16];

    function automatic int unsigned b(input int r);
        return 32'd1 << r;
    endfunction

    function automatic vec_t v(input int av, input int aa, input int unsigned ad,
                               input int mv, input int ma, input int unsigned md,
                               input int e, input int ea, input int unsigned ed,
                               input int ec, input int unsigned ep);
        vec_t t;
        t.av = 1'(av);     t.aa = 5'(aa);     t.ad = ad;
        t.mv = 1'(mv);     t.ma = 5'(ma);     t.md = md;
        t.e_enc = 1'(e);   t.e_addr = 5'(ea); t.e_data = ed;
        t.e_cnt = 3'(ec);  t.e_pend = ep;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random-phase scoreboard state.
    wb_entry_t   q_alu[$];
    wb_entry_t   q_mem[$];
    logic [31:0] model_rf [32];
    logic [31:0] obs_rf   [32];

    task automatic observe();
        wb_entry_t e;
        if (bus.enc) begin
            obs_rf[bus.addrc] = bus.datac;
            if (bus.addrc >= 5'd16) begin
                if (q_mem.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rnd mem extra write: got addr %0d, expected none", bus.addrc);
                end else begin
                    e = q_mem.pop_front();
                    check("rnd mem write", 64'({bus.addrc, bus.datac}), 64'({e.addr, e.data}));
                end
            end else begin
                if (q_alu.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rnd alu extra write: got addr %0d, expected none", bus.addrc);
                end else begin
                    e = q_alu.pop_front();
                    check("rnd alu write", 64'({bus.addrc, bus.datac}), 64'({e.addr, e.data}));
                end
            end
        end
    endtask

    initial begin
        int          k;
        int          got[$];
        int          exp_order[12];
        logic        av, mv;
        logic [4:0]  aa, ma;
        logic [31:0] ad, md;

        // Directed table: inputs for one cycle, outputs expected right after the edge.
        vecs[0]  = v(1,  7, 'hAA, 0,  0, 'h00, 1,  7, 'hAA, 0, b(7));
        vecs[1]  = v(0,  0, 'h00, 0,  0, 'h00, 0,  7, 'hAA, 0, 0);
        vecs[2]  = v(1,  9, 'h22, 1,  3, 'h11, 1,  3, 'h11, 1, b(3) | b(9));
        vecs[3]  = v(0,  0, 'h00, 0,  0, 'h00, 1,  9, 'h22, 0, b(9));
        vecs[4]  = v(0,  0, 'h00, 0,  0, 'h00, 0,  9, 'h22, 0, 0);
        vecs[5]  = v(1,  0, 'hFFFF_FFFF, 1, 0, 'h55, 0, 9, 'h22, 0, 0);
        vecs[6]  = v(1,  0, 'h12, 1,  5, 'h66, 1,  5, 'h66, 0, b(5));
        vecs[7]  = v(1, 12, 'h34, 1,  0, 'h77, 1, 12, 'h34, 0, b(12));
        vecs[8]  = v(1, 13, 'h0D, 1,  4, 'h44, 1,  4, 'h44, 1, b(4) | b(13));
        vecs[9]  = v(1, 14, 'h0E, 1,  0, 'h99, 1, 13, 'h0D, 1, b(13) | b(14));
        vecs[10] = v(0,  0, 'h00, 0,  0, 'h00, 1, 14, 'h0E, 0, b(14));
        vecs[11] = v(0,  0, 'h00, 0,  0, 'h00, 0, 14, 'h0E, 0, 0);
        vecs[12] = v(1,  6, 'hA1, 1,  2, 'h01, 1,  2, 'h01, 1, b(2) | b(6));
        vecs[13] = v(1,  6, 'hA2, 0,  0, 'h00, 1,  6, 'hA1, 1, b(6));
        vecs[14] = v(0,  0, 'h00, 0,  0, 'h00, 1,  6, 'hA2, 0, b(6));
        vecs[15] = v(0,  0, 'h00, 0,  0, 'h00, 0,  6, 'hA2, 0, 0);

        exp_order = '{20, 21, 22, 23, 24, 25, 1, 2, 3, 4, 5, 6};

        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset enc", 64'(bus.enc), 64'(0));
        check("reset addrc", 64'(bus.addrc), 64'(0));
        check("reset datac", 64'(bus.datac), 64'(0));
        check("reset pending", 64'(bus.pending), 64'(0));
        check("reset count", 64'(bus.fifo_count), 64'(0));
        check("reset ready", 64'(bus.alu_ready), 64'(1));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
            if (i == 5) check("reg0 ready", 64'(bus.alu_ready), 64'(1));
            tick();
            check($sformatf("vec%0d enc", i), 64'(bus.enc), 64'(vecs[i].e_enc));
            check($sformatf("vec%0d addrc", i), 64'(bus.addrc), 64'(vecs[i].e_addr));
            check($sformatf("vec%0d datac", i), 64'(bus.datac), 64'(vecs[i].e_data));
            check($sformatf("vec%0d count", i), 64'(bus.fifo_count), 64'(vecs[i].e_cnt));
            check($sformatf("vec%0d ready", i), 64'(bus.alu_ready),
                  64'(vecs[i].e_cnt < 3'd4));
            check($sformatf("vec%0d pending", i), 64'(bus.pending), 64'(vecs[i].e_pend));
        end

        // Full FIFO: loads hold the port for 6 cycles while ALU streams 1..6.
        idle();
        k = 1;
        for (int c = 0; c < 20; c++) begin
            if (c < 6) begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = 5'(20 + c);
                bus.mem_data  = 32'(32'h200 + c);
            end else begin
                bus.mem_valid = 1'b0;
            end
            bus.alu_valid = (k <= 6);
            bus.alu_addr  = 5'(k);
            bus.alu_data  = 32'(32'h100 + k);
            if (c == 4 || c == 5) begin
                check($sformatf("full ready c%0d", c), 64'(bus.alu_ready), 64'(0));
                check($sformatf("full count c%0d", c), 64'(bus.fifo_count), 64'(4));
            end
            if (bus.alu_valid && bus.alu_ready) k++;
            tick();
            if (bus.enc) got.push_back(int'(bus.addrc));
        end
        check("full write count", 64'(got.size()), 64'(12));
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            check($sformatf("full order %0d", i), 64'(got[i]), 64'(exp_order[i]));
        end

        // Reset with three ALU entries queued behind loads.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'(10 + c), 32'(32'hC0 + c), 1'b1, 5'(20 + c), 32'(32'hD0 + c));
            tick();
        end
        check("pre-reset count", 64'(bus.fifo_count), 64'(3));
        idle();
        rst_n = 1'b0;
        #1;
        check("async reset enc", 64'(bus.enc), 64'(0));
        check("async reset pending", 64'(bus.pending), 64'(0));
        check("async reset count", 64'(bus.fifo_count), 64'(0));
        check("async reset ready", 64'(bus.alu_ready), 64'(1));
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("post-reset enc c%0d", c), 64'(bus.enc), 64'(0));
        end
        check("post-reset pending", 64'(bus.pending), 64'(0));

        // Random traffic: ALU targets 1..15, loads 16..31, occasional register 0.
        for (int r = 0; r < 32; r++) begin
            model_rf[r] = 32'd0;
            obs_rf[r]   = 32'd0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            av = ($urandom_range(0, 99) < 60);
            aa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
            ad = $urandom;
            mv = ($urandom_range(0, 99) < 40);
            ma = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
            md = $urandom;
            drive(av, aa, ad, mv, ma, md);
            assert (!(av && mv && aa != 5'd0 && aa == ma));
            if (av && bus.alu_ready && aa != 5'd0) begin
                q_alu.push_back('{addr: aa, data: ad});
                model_rf[aa] = ad;
            end
            if (mv && ma != 5'd0) begin
                q_mem.push_back('{addr: ma, data: md});
                model_rf[ma] = md;
            end
            tick();
            observe();
        end
        idle();
        for (int d = 0; d < 12; d++) begin
            tick();
            observe();
        end
        check("rnd alu leftover", 64'(q_alu.size()), 64'(0));
        check("rnd mem leftover", 64'(q_mem.size()), 64'(0));
        check("rnd final count", 64'(bus.fifo_count), 64'(0));
        for (int r = 0; r < 32; r++) begin
            check($sformatf("rnd rf[%0d]", r), 64'(obs_rf[r]), 64'(model_rf[r]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Writeback stage directly upstream of the register file's single write port (`enc`/`addrc`/`datac`).
- Merges two result producers into that one write per cycle: the ALU stage and the memory/load stage.
- Memory results take priority; ALU results that lose arbitration are buffered in a small in-order FIFO.
- Publishes a per-register pending bitmap so issue logic stalls readers and writers of registers not yet written.

Parameters:
- DEPTH, 4, ALU overflow FIFO entries (power of two, >=2).
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load result present; always accepted, no back-pressure.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load result.
- enc  out  1  register-file write enable (registered).
- addrc  out  ADDR_W  register-file write address (registered).
- datac  out  DATA_W  register-file write data (registered).
- pending  out  2**ADDR_W  bit r=1 while a write to register r is queued or held in the output register.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - enc=0, addrc=0, datac=0, pending=0, fifo_count=0.
  - FIFO pointers cleared; all in-flight entries are discarded, including on reset mid-operation.
- alu_ready is combinational and equals (fifo_count < DEPTH). It does not depend on mem_valid or on a same-cycle pop, so there is no push-on-full.
- Per-cycle source selection for the output register, in priority order:
  1. mem_valid=1 -> load result.
  2. Else FIFO non-empty -> pop head.
  3. Else alu_valid=1 (accepted) -> ALU result directly (bypass).
  4. Else enc<=0. addrc/datac hold their previous values.
- An accepted ALU result that is not selected in the same cycle is pushed to the FIFO tail. Pushes happen when mem_valid=1, or when the FIFO is non-empty.
- Latency:
  - Selected result appears on enc/addrc/datac one cycle after acceptance.
  - The register file commits it on the following edge.
- Ordering:
  - ALU results are written in acceptance order; the bypass is never taken while the FIFO is non-empty.
  - Load results may overtake queued ALU results.
- Register 0:
  - Results addressed to 0 are accepted (ALU consumes a handshake) but produce no FIFO entry, no enc pulse and no pending bit.
  - Selection then proceeds as if that source were absent.
- Simultaneous push and pop in one cycle: fifo_count unchanged, pointers wrap modulo DEPTH.
- pending:
  - Bit set on the edge an entry enters the FIFO or the output register with enc=1.
  - Bit cleared when the entry leaves the output register, unless another queued entry or the new output entry targets the same register.
  - Computed as the OR over valid FIFO entries plus the output register.
- Contract: issue logic never lets a load and an ALU result target the same register while either is pending. The bench asserts this; the block is not required to resolve it.
- No combinational path from any input to enc/addrc/datac/pending.

Decomposition:
- Shared CPU package holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - A writeback-entry struct {addr, data}.
- One sub-module, wb_fifo: synchronous DEPTH-entry FIFO with push/pop/count and a per-entry valid+addr view for the pending OR. The arbiter holds selection, the output register and the bitmap.

Test Plan:
- Reset: drive mid-traffic with 3 entries queued, pull reset low -> immediately enc=0, pending=0, fifo_count=0, alu_ready=1; after release, no stale write ever appears.
- Bypass: alu_valid=1, addr=7, data=0x0000_00AA with FIFO empty -> next cycle enc=1, addrc=7, datac=0xAA, pending[7]=1; one cycle later pending[7]=0.
- Conflict: same cycle mem 3/0x11 and alu 9/0x22 -> cycle+1 writes 3/0x11 with fifo_count=1 and pending[9]=1; cycle+2 writes 9/0x22.
- Full FIFO:
  - Stimulus: mem_valid held 1 for 6 cycles with ALU streaming addrs 1..6.
  - Required: alu_ready drops after 4 pushes; then ALU 1..4 drain in order, followed by 5 and 6.
- Register 0: alu addr 0 data 0xFFFF_FFFF and mem addr 0 -> alu_ready=1, no enc pulse, pending[0] stays 0.
- Random: 2000 cycles of random valids and non-conflicting addresses; a scoreboard checks the register-file contents against a reference model, per-source in-order commit, and exactly one write per accepted non-zero result.
